// File: rtl/rr_mux_nx1.sv
// N-to-1 registered multiplexer with fixed-select or round-robin arbitration.
// One output register slot; a new word can load in the same cycle the held word drains.
module rr_mux_nx1 #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t             state, next_state;
  logic [SEL_W-1:0]   last_ptr;
  logic [SEL_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               load_en;
  logic               xfer;
  int unsigned        cand;

  // Grant selection: fixed index in mode 0, rotating search after last_ptr in mode 1
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (!mode) begin
      if ((32'(sel) < CHANNELS) && in_valid[sel]) begin
        gnt_any = 1'b1;
        gnt_idx = sel;
      end
    end else begin
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
        cand = 32'(last_ptr) + k;
        if (cand >= CHANNELS) cand = cand - CHANNELS;
        if (!gnt_any && in_valid[cand[SEL_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = cand[SEL_W-1:0];
        end
      end
    end
  end

  assign load_en   = (state == IDLE) | out_ready;
  // Reset suppresses any transfer so a word is never accepted and then discarded
  assign xfer      = load_en & gnt_any & ~reset;
  assign in_ready  = xfer ? (CHANNELS'(1) << gnt_idx) : '0;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (xfer)         next_state = FULL;
    else if (load_en) next_state = IDLE;
  end

  // Output word, source index and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_chan <= '0;
      last_ptr <= SEL_W'(CHANNELS - 1);
    end else if (xfer) begin
      out_data <= in_data[32'(gnt_idx)*WIDTH +: WIDTH];
      out_chan <= gnt_idx;
      if (mode) last_ptr <= gnt_idx;
    end
  end

endmodule

// File: doc/rr_mux_nx1.md
RR_MUX_NX1 -- requirements
Module: rr_mux_nx1

Interface
REQ-001 Parameter: WIDTH, 32, data bits per channel.
REQ-002 Parameter: CHANNELS, 8, number of input channels (2..16).
REQ-003 Parameter: SEL_W, 3, select/channel-index width; SEL_W = ceil(log2(CHANNELS)).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: in_data  input  CHANNELS*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port: in_valid  input  CHANNELS  per-channel valid.
REQ-008 Port: in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle.
REQ-009 Port: mode  input  1  0 = fixed select by sel; 1 = round-robin arbitration.
REQ-010 Port: sel  input  SEL_W  channel index used when mode = 0.
REQ-011 Port: out_data  output  WIDTH  registered selected data.
REQ-012 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-013 Port: out_ready  input  1  downstream accepts out_data this cycle.
REQ-014 Port: out_chan  output  SEL_W  index of the channel that supplied out_data.

Function
REQ-015 Transfer on channel i SHALL occur in a cycle where in_valid[i] and in_ready[i] are both high; output handoff SHALL occur where out_valid and out_ready are both high.
REQ-016 load_en SHALL be (!out_valid) or out_ready; in_ready SHALL be all-zero when load_en is low.
REQ-017 Mode 0: grant SHALL go to channel sel only if sel < CHANNELS and in_valid[sel]; otherwise no grant.
REQ-018 Mode 0: sel >= CHANNELS SHALL produce no grant, no transfer, and no error state.
REQ-019 Mode 1: grant SHALL go to the first channel with in_valid high, searching from (last_ptr+1) mod CHANNELS upward with wrap-around.
REQ-020 last_ptr SHALL update to the granted index on every transfer in mode 1 and SHALL be unchanged in mode 0 and in cycles with no transfer.
REQ-021 in_ready[i] SHALL be high iff load_en and channel i holds the grant; in_ready is combinational from in_valid, mode, sel, out_valid, out_ready, last_ptr.
REQ-022 On transfer, out_data, out_chan SHALL load the granted channel's data and index at the next edge, and out_valid SHALL be 1 (latency one cycle).
REQ-023 If load_en and no grant, out_valid SHALL clear to 0 at the next edge; out_data and out_chan SHALL hold their previous values.
REQ-024 While out_valid and !out_ready, out_data, out_valid and out_chan SHALL remain stable.
REQ-025 Simultaneous handoff and new transfer in one cycle SHALL sustain one word per cycle with no bubble.
REQ-026 A change of mode or sel SHALL affect only arbitration of the current cycle; it SHALL never alter a held output word.
REQ-027 Arbiter states: IDLE (out_valid = 0) and FULL (out_valid = 1); IDLE->FULL on transfer, FULL->IDLE on handoff without transfer, FULL->FULL on stall or handoff-with-transfer.

Reset
REQ-028 While reset is high at a rising edge: out_valid = 0, out_data = 0, out_chan = 0, last_ptr = CHANNELS-1 (first round-robin grant favours channel 0).
REQ-029 During a reset cycle in_ready SHALL be all-zero; a held word SHALL be discarded by reset.
REQ-030 Reset asserted mid-stream SHALL take effect at the next edge regardless of out_ready or in_valid.

Verification
REQ-031 Reset then mode=0, sel=5, in_valid=8'h20, ch5=32'hDEADBEEF, out_ready=1 -> in_ready=8'h20, next cycle out_valid=1, out_data=32'hDEADBEEF, out_chan=5.
REQ-032 mode=1, in_valid=8'hFF held, out_ready=1 for 10 cycles after reset -> out_chan sequence 0,1,2,...,7,0,1; one word per cycle.
REQ-033 mode=1, in_valid=8'h81, out_ready=1 -> grants alternate 0,7,0,7; last_ptr wraps 7->0.
REQ-034 Output full with ch2 word, out_ready=0 for 3 cycles while in_valid=8'hFF -> in_ready=0, out_data/out_chan stable at ch2 for all 3 cycles; with out_ready=1 in the next cycle, the following word (ch3 in mode 1) loads with no bubble.
REQ-035 CHANNELS=6, SEL_W=3, mode=0, sel=7, in_valid=6'h3F -> in_ready=0, out_valid falls to 0 after pending word drains.
REQ-036 Reset asserted with out_valid=1, out_ready=0 -> next cycle out_valid=0, out_data=0, out_chan=0; first mode-1 grant afterward is channel 0.
